// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader: FSM state
// encodings, stream field sizes and a small state-decoding helper.
package instr_mem_loader_pkg;

  // Loader FSM states, explicit 3-bit encodings
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // Stream field sizes in bytes
  localparam int LEN_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  // Derived field widths in bits
  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int CSUM_W = 8 * CSUM_BYTES;

  // States in which the loader is consuming the byte stream
  function automatic logic is_busy(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Packs a byte stream into little-endian 32-bit words. The word is valid for
// exactly one cycle after its fourth byte is accepted; the first byte of the
// next word may be accepted in that same cycle.
module byte_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [1:0]  lane_p0;
  logic [31:0] shreg_p1;
  logic        vld_p1;

  // Lane counter and shift register; new bytes enter at the top so that after
  // four bytes the register reads {b3,b2,b1,b0}
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_p0  <= '0;
      shreg_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (clear) begin
      lane_p0  <= '0;
      shreg_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= byte_vld && (lane_p0 == 2'd3);
      if (byte_vld) begin
        lane_p0  <= lane_p0 + 2'd1;
        shreg_p1 <= {byte_data, shreg_p1[31:8]};
      end
    end
  end

  assign last_lane = (lane_p0 == 2'd3);
  assign word_vld  = vld_p1;
  assign word      = shreg_p1;

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader in front of the core: receives LEN_LO, LEN_HI, 4*N payload bytes
// and an XOR checksum, writes the words to instruction memory and releases the
// core (cpu_run) only once the whole image is in and the checksum matches.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t              state, state_nxt;
  logic [7:0]          len_lo_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    len_full;
  logic [CSUM_W-1:0]   csum_q;
  logic [ADDR_W:0]     word_count_q;
  logic                xfer;
  logic                start_load;
  logic                pack_vld;
  logic                last_lane;
  logic                last_word;
  logic                word_vld;
  logic [31:0]         word;

  assign busy       = is_busy(state);
  assign in_ready   = busy;
  assign xfer       = in_valid && in_ready;
  assign start_load = start && !busy;
  assign len_full   = {in_data, len_lo_q};
  // The previous word's write has always retired by the time a lane-3 byte
  // arrives, so word_count is the number of completed words here
  assign last_word  = (LEN_W'(word_count_q) + LEN_W'(1)) == len_q;
  assign pack_vld   = xfer && (state == ST_DATA);

  byte_word_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_load),
    .byte_vld  (pack_vld),
    .byte_data (in_data),
    .last_lane (last_lane),
    .word_vld  (word_vld),
    .word      (word)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode driven by start and accepted stream bytes
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_nxt = ST_LEN0;
      end
      ST_LEN0: begin
        if (xfer) state_nxt = ST_LEN1;
      end
      ST_LEN1: begin
        if (xfer) begin
          if (len_full == '0)          state_nxt = ST_CHECK;
          else if (len_full > MAX_LEN) state_nxt = ST_ERROR;
          else                         state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer && last_lane && last_word) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) state_nxt = (in_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Length, checksum accumulator and written-word counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_lo_q     <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      word_count_q <= '0;
    end else if (start_load) begin
      csum_q       <= '0;
      word_count_q <= '0;
    end else begin
      if (xfer && (state == ST_LEN0)) len_lo_q <= in_data;
      if (xfer && (state == ST_LEN1)) len_q    <= len_full;
      if (pack_vld)                   csum_q   <= csum_q ^ in_data;
      if (word_vld)                   word_count_q <= word_count_q + 1'b1;
    end
  end

  assign imem_we    = word_vld;
  assign imem_addr  = word_count_q[ADDR_W-1:0];
  assign imem_wdata = word;
  assign word_count = word_count_q;
  assign cpu_run    = (state == ST_DONE);
  assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus random
// images, checked against an image-level reference model.
module tb_instr_mem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clock;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   word_count;

  instr_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .error      (error),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  logic [7:0]        stream[$];
  logic [7:0]        pay[$];
  int                xfer_cyc[$];
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  int                wc[$];

  // Log every instruction-memory write
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); xfer_cyc.delete();
  endtask

  // Build a stream of n words with random payload; bad flips one checksum bit
  task automatic make_image(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] cs;
    logic [7:0] flip;
    stream.delete(); pay.delete();
    cs = 8'h00;
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      pay.push_back(b);
      stream.push_back(b);
      cs = cs ^ b;
    end
    if (bad) begin
      flip = 8'h01 << $urandom_range(0, 7);
      cs = cs ^ flip;
    end
    stream.push_back(cs);
  endtask

  // Offer the first count stream bytes; gapmode 0=none, 1=every other cycle, 2=random
  task automatic send(input int count, input int gapmode, input bit poke_start);
    int t;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      t = 0;
      @(negedge clock);
      while (in_ready !== 1'b1 && t < 40) begin
        @(negedge clock);
        t++;
      end
      if (in_ready !== 1'b1) begin
        chk($sformatf("xfer_timeout_byte%0d", i), in_ready, 1);
        in_valid = 1'b0;
        tick();
        return;
      end
      xfer_cyc.push_back(cyc);
      tick();
      if (poke_start && i == 5) begin
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // Compare logged writes with the words the image should produce
  task automatic check_writes(input int n, input string tag);
    logic [31:0] w;
    int m;
    chk({tag, "_nwrites"}, wa.size(), n);
    m = (wa.size() < n) ? wa.size() : n;
    for (int i = 0; i < m; i++) begin
      w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      chk($sformatf("%s_addr%0d", tag, i), wa[i], i[ADDR_W-1:0]);
      chk($sformatf("%s_data%0d", tag, i), wd[i], w);
      if (xfer_cyc.size() > 4*i+5)
        chk($sformatf("%s_lat%0d", tag, i), wc[i], xfer_cyc[4*i+5] + 1);
    end
  endtask

  task automatic check_end(input string tag, input bit done, input int wcnt);
    tick();
    tick();
    chk({tag, "_cpu_run"}, cpu_run, done);
    chk({tag, "_error"}, error, !done);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_word_count"}, word_count, wcnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // 1. reset state and idle input rejection
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    tick();
    reset = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("idle_nwrites", wa.size(), 0);

    // 2. single-word fixed image, no gaps
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'hA0, 8'h00, 8'hB3};
    pay    = '{8'h13, 8'h00, 8'hA0, 8'h00};
    clear_logs();
    pulse_start();
    send(stream.size(), 0, 1'b0);
    check_writes(1, "t2");
    if (wd.size() > 0) chk("t2_word", wd[0], 32'h00A00013);
    check_end("t2", 1'b1, 1);

    // 3. three words, valid toggling every other cycle
    make_image(3, 1'b0);
    clear_logs();
    pulse_start();
    send(stream.size(), 1, 1'b0);
    check_writes(3, "t3");
    check_end("t3", 1'b1, 3);

    // 4. same image with one checksum bit flipped, then recovery
    stream[stream.size()-1] = stream[stream.size()-1] ^ (8'h01 << $urandom_range(0, 7));
    clear_logs();
    pulse_start();
    send(stream.size(), 0, 1'b0);
    check_writes(3, "t4bad");
    check_end("t4bad", 1'b0, 3);
    n = $urandom_range(1, 6);
    make_image(n, 1'b0);
    clear_logs();
    pulse_start();
    send(stream.size(), 2, 1'b0);
    check_writes(n, "t4ok");
    check_end("t4ok", 1'b1, n);

    // 5. oversize length rejected after LEN_HI; zero length accepted
    stream = '{8'h01, 8'h01};
    clear_logs();
    pulse_start();
    send(2, 0, 1'b0);
    chk("t5big_error", error, 1);
    chk("t5big_busy", busy, 0);
    chk("t5big_cpu_run", cpu_run, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    chk("t5big_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    chk("t5big_nwrites", wa.size(), 0);
    make_image(0, 1'b0);
    clear_logs();
    pulse_start();
    send(stream.size(), 0, 1'b0);
    check_writes(0, "t5zero");
    check_end("t5zero", 1'b1, 0);

    // 6. asynchronous reset in the middle of a word, then full reload
    make_image(1, 1'b0);
    clear_logs();
    pulse_start();
    send(4, 0, 1'b0);
    #3 reset = 1'b0;
    #2;
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_word_count", word_count, 0);
    chk("t6_imem_we", imem_we, 0);
    chk("t6_imem_wdata", imem_wdata, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_nwrites", wa.size(), 0);
    clear_logs();
    pulse_start();
    send(stream.size(), 0, 1'b0);
    check_writes(1, "t6");
    check_end("t6", 1'b1, 1);

    // 7. random images with random gaps; one start poked mid-load, one bad checksum
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 12);
      make_image(n, k == 3);
      clear_logs();
      pulse_start();
      send(stream.size(), 2, k == 1);
      check_writes(n, $sformatf("t7_%0d", k));
      check_end($sformatf("t7_%0d", k), k != 3, n);
    end

    // 8. largest legal image fills every address
    make_image(MAX_WORDS, 1'b0);
    clear_logs();
    pulse_start();
    send(stream.size(), 0, 1'b0);
    check_writes(MAX_WORDS, "t8");
    check_end("t8", 1'b1, MAX_WORDS);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
